// File: rtl/fir_decim_sink.sv
// fir_decim_sink: decimating sink at the end of the FIR sample stream.
// Keeps one strobed sample in every DECIM, requantises it to OUT_WIDTH,
// buffers it in a first-word fall-through FIFO and hands it downstream
// on a valid/ready handshake.
// Optional feature macro: FIR_DECIM_ROUND_EN
//   defined   -> round half up with saturation
//   undefined -> plain truncation (floor)
module fir_decim_sink #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic signed [DATA_WIDTH-1:0]  i_data,
  input  logic                          i_ovf_clr,
  output logic signed [OUT_WIDTH-1:0]   o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

  localparam int D    = DATA_WIDTH - OUT_WIDTH;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

`ifdef FIR_DECIM_ROUND_EN
  localparam logic [DATA_WIDTH:0] HALF =
    (D > 0) ? ((DATA_WIDTH+1)'(1) << ((D > 0) ? D - 1 : 0)) : '0;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`endif

  // Drop the D low bits of a sample, optionally rounding half up first.
  function automatic logic signed [OUT_WIDTH-1:0] requant(
    input logic signed [DATA_WIDTH-1:0] x
  );
`ifdef FIR_DECIM_ROUND_EN
    logic [DATA_WIDTH:0] sum;
    // One guard bit above the sign catches the carry out of the rounding add.
    sum = {x[DATA_WIDTH-1], x} + HALF;
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      requant = sum[DATA_WIDTH] ? OUT_MIN : OUT_MAX;
    end else begin
      requant = sum[DATA_WIDTH-1:D];
    end
`else
    requant = x[DATA_WIDTH-1:D];
`endif
  endfunction

  logic [PH_W-1:0]                phase_q, phase_d;
  logic                           keep;
  logic                           stg_vld_q;
  logic signed [OUT_WIDTH-1:0]    stg_data_q;
  logic signed [OUT_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]                  lvl_q, lvl_d;
  logic                           ovf_q, ovf_d;
  logic signed [OUT_WIDTH-1:0]    hold_q, hold_d;
  logic                           full, pop, push;

  assign keep = i_en && (phase_q == '0);
  assign full = (lvl_q == LW'(FIFO_DEPTH));
  assign pop  = (lvl_q != '0) && i_ready;
  assign push = stg_vld_q && (!full || pop);

  // Next-state for the decimation phase counter; moves only on strobes.
  always_comb begin
    phase_d = phase_q;
    if (i_en) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
    end
  end

  // Next-state for FIFO pointers, occupancy, sticky overflow and the empty-hold value.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    ovf_d  = ovf_q;
    hold_d = hold_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop) begin
      rd_d   = rd_q + AW'(1);
      hold_d = mem_q[rd_q];
    end
    if (push && !pop) begin
      lvl_d = lvl_q + LW'(1);
    end else if (!push && pop) begin
      lvl_d = lvl_q - LW'(1);
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (stg_vld_q && full && !pop) begin
      ovf_d = 1'b1;
    end else if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state register; async reset discards any staged sample and empties the FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q   <= '0;
      stg_vld_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      stg_vld_q <= keep;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      ovf_q     <= ovf_d;
      hold_q    <= hold_d;
    end
  end

  // Convert stage data: requantised kept sample, qualified by stg_vld_q.
  always_ff @(posedge i_clk) begin
    if (keep) stg_data_q <= requant(i_data);
  end

  // FIFO storage; an occupied entry is never overwritten because push requires space.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= stg_data_q;
  end

  // Head entry when non-empty, otherwise the last value handed out (0 after reset).
  assign o_data     = (lvl_q != '0) ? mem_q[rd_q] : hold_q;
  assign o_valid    = (lvl_q != '0);
  assign o_level    = lvl_q;
  assign o_overflow = ovf_q;

endmodule
